grid_lookup_arbiter: RTL and testbench

Round-robin arbiter that shares the single pixel-to-grid converter (`gridalizer`) between up to `N_REQ` requesters, such as the player, enemies, projectiles and the cursor.
- Each requester submits a pixel position and gets an `ack`.
- Two cycles after its request is sampled, it receives the grid cell on a shared response bus, tagged by a one-hot `rsp_valid`.
- Sits between the game-logic sprites and the converter; sustains one lookup per clock.

---
 rtl/grid_lookup_arbiter.sv | 148 ++++++++++++++
 tb/tb_grid_lookup_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_lookup_arbiter.sv
// grid_lookup_arbiter: round-robin sharing of one pixel-to-grid converter
// between N_REQ requesters. A grant registers the winner's pixel position
// onto gz_pos_*, acks the winner for one cycle, and the result returns on
// the shared rsp bus two edges after the grant, tagged by one-hot rsp_valid.
// Optional feature macro: GRID_ARB_PRIO0_EN (requester 0 gets fixed top
// priority; round-robin among the rest).
module grid_lookup_arbiter #(
  parameter int N_REQ    = 4,
  parameter int GRID_X_W = 6,
  parameter int GRID_Y_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*11-1:0]   req_h,
  input  logic [N_REQ*10-1:0]   req_v,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [GRID_X_W-1:0]   rsp_grid_x,
  output logic [GRID_Y_W-1:0]   rsp_grid_y,
  output logic [10:0]           gz_pos_h,
  output logic [9:0]            gz_pos_v,
  input  logic [GRID_X_W-1:0]   gz_grid_x,
  input  logic [GRID_Y_W-1:0]   gz_grid_y
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    ack_q;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [10:0]         gz_pos_h_q;
  logic [9:0]          gz_pos_v_q;
  logic                s1_v_q, s2_v_q;
  logic [PW-1:0]       s1_idx_q, s2_idx_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [GRID_X_W-1:0] rsp_grid_x_q;
  logic [GRID_Y_W-1:0] rsp_grid_y_q;

  logic [N_REQ-1:0]    elig;
  logic                grant_v;
  logic [PW-1:0]       grant_idx;
  logic [N_REQ-1:0]    grant_oh;
  logic [N_REQ-1:0]    s2_oh;
  logic [10:0]         win_h;
  logic [9:0]          win_v;

  assign ack        = ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_grid_x = rsp_grid_x_q;
  assign rsp_grid_y = rsp_grid_y_q;
  assign gz_pos_h   = gz_pos_h_q;
  assign gz_pos_v   = gz_pos_v_q;

  // Pick the winner: first eligible index after ptr, wrapping around.
  always_comb begin
    elig      = req & ~ack_q;
    grant_v   = 1'b0;
    grant_idx = '0;
    ptr_d     = ptr_q;
`ifdef GRID_ARB_PRIO0_EN
    if (elig[0]) begin
      grant_v   = 1'b1;
      grant_idx = '0;
    end else begin
      // Rotation covers 1..N_REQ-1 only, so ptr never holds 0 here and a
      // single subtraction is enough to wrap.
      for (int unsigned off = 1; off < N_REQ; off++) begin
        int unsigned cand;
        cand = int'(ptr_q) + off;
        if (cand > N_REQ - 1) cand = cand - (N_REQ - 1);
        if (!grant_v && elig[cand[PW-1:0]]) begin
          grant_v   = 1'b1;
          grant_idx = cand[PW-1:0];
        end
      end
      if (grant_v) ptr_d = grant_idx;
    end
`else
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      int unsigned cand;
      cand = (int'(ptr_q) + off) % N_REQ;
      if (!grant_v && elig[cand[PW-1:0]]) begin
        grant_v   = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    if (grant_v) ptr_d = grant_idx;
`endif
  end

  // Decode winner and stage-2 tag into one-hot vectors; select winner position.
  always_comb begin
    grant_oh = '0;
    s2_oh    = '0;
    if (grant_v) grant_oh[grant_idx] = 1'b1;
    s2_oh[s2_idx_q] = 1'b1;
    win_h = req_h[11*int'(grant_idx) +: 11];
    win_v = req_v[10*int'(grant_idx) +: 10];
  end

  // Grant register: ack, pointer and converter position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= '0;
      ptr_q      <= PW'(N_REQ - 1);
      gz_pos_h_q <= '0;
      gz_pos_v_q <= '0;
    end else begin
      ack_q <= grant_oh;
      ptr_q <= ptr_d;
      if (grant_v) begin
        gz_pos_h_q <= win_h;
        gz_pos_v_q <= win_v;
      end
    end
  end

  // Two-stage tag pipeline tracking which requester owns the converter result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_idx_q <= '0;
      s2_v_q   <= 1'b0;
      s2_idx_q <= '0;
    end else begin
      s1_v_q   <= grant_v;
      s1_idx_q <= grant_idx;
      s2_v_q   <= s1_v_q;
      s2_idx_q <= s1_idx_q;
    end
  end

  // Response register: capture converter output when a tagged result is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rsp_grid_x_q <= '0;
      rsp_grid_y_q <= '0;
    end else begin
      rsp_valid_q <= s2_v_q ? s2_oh : '0;
      if (s2_v_q) begin
        rsp_grid_x_q <= gz_grid_x;
        rsp_grid_y_q <= gz_grid_y;
      end
    end
  end

endmodule

// File: tb/tb_grid_lookup_arbiter.sv
// Directed bench for grid_lookup_arbiter with a behavioural converter
// (8-pixel columns, 12-pixel rows, clamped to the grid width) and a
// scoreboard queue of expected responses.
module tb_grid_lookup_arbiter;

  localparam int N = 4;
  localparam int XW = 6;
  localparam int YW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*11-1:0] req_h = '0;
  logic [N*10-1:0] req_v = '0;
  logic [N-1:0]    ack, rsp_valid;
  logic [XW-1:0]   rsp_grid_x;
  logic [YW-1:0]   rsp_grid_y;
  logic [10:0]     gz_pos_h;
  logic [9:0]      gz_pos_v;
  logic [XW-1:0]   gz_grid_x = '0;
  logic [YW-1:0]   gz_grid_y = '0;

  grid_lookup_arbiter #(.N_REQ(N), .GRID_X_W(XW), .GRID_Y_W(YW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_h(req_h), .req_v(req_v),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_grid_x(rsp_grid_x),
    .rsp_grid_y(rsp_grid_y), .gz_pos_h(gz_pos_h), .gz_pos_v(gz_pos_v),
    .gz_grid_x(gz_grid_x), .gz_grid_y(gz_grid_y)
  );

  always #5 clk = ~clk;

  function automatic logic [XW-1:0] cx(input logic [10:0] h);
    int q;
    q = int'(h) / 8;
    return (q > 63) ? 6'd63 : q[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] cy(input logic [9:0] v);
    int q;
    q = int'(v) / 12;
    return (q > 31) ? 5'd31 : q[YW-1:0];
  endfunction

  // Converter model: registered, one-cycle latency.
  always @(posedge clk) begin
    gz_grid_x <= cx(gz_pos_h);
    gz_grid_y <= cy(gz_pos_v);
  end

  typedef struct {
    int            due;
    int            idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_pos(input int i, input int h, input int v);
    req_h[11*i +: 11] = 11'(h);
    req_v[10*i +: 10] = 10'(v);
  endtask

  // One clock edge; g is the requester expected to win at this edge (-1: none).
  task automatic tick(input int g);
    exp_t          e;
    logic [N-1:0]  ea;
    logic [N-1:0]  ev;
    ea = '0;
    if (g >= 0) begin
      ea[g] = 1'b1;
      e.due = cyc + 3;
      e.idx = g;
      e.x   = cx(req_h[11*g +: 11]);
      e.y   = cy(req_v[10*g +: 10]);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("ack", 32'(ack), 32'(ea));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e  = sbq.pop_front();
      ev = '0;
      ev[e.idx] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_grid_x", 32'(rsp_grid_x), 32'(e.x));
      chk("rsp_grid_y", 32'(rsp_grid_y), 32'(e.y));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_x"}, 32'(rsp_grid_x), 32'd0);
    chk({tag, "_rsp_y"}, 32'(rsp_grid_y), 32'd0);
    chk({tag, "_gz_h"}, 32'(gz_pos_h), 32'd0);
    chk({tag, "_gz_v"}, 32'(gz_pos_v), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single lookup on requester 2
    set_pos(2, 100, 50);
    req = 4'b0100;
    tick(2);
    req = '0;
    tick(-1);
    tick(-1);
    chk("single_x12", 32'(rsp_grid_x), 32'd12);
    chk("single_y4", 32'(rsp_grid_y), 32'd4);

    // Clamp passthrough on requester 1
    set_pos(1, 700, 30);
    req = 4'b0010;
    tick(1);
    req = '0;
    tick(-1);
    tick(-1);
    chk("clamp_x", 32'(rsp_grid_x), 32'd63);

    // Reset one cycle after a grant: lookup dropped
    set_pos(3, 200, 100);
    req = 4'b1000;
    tick(3);
    req = '0;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    sbq.delete();
    tick(-1);
    tick(-1);
    tick(-1);
    rst = 1'b0;

    // All four held with distinct positions; first grant after reset is 0
    set_pos(0, 16, 24);
    set_pos(1, 80, 120);
    set_pos(2, 300, 240);
    set_pos(3, 511, 360);
    req = 4'b1111;
    tick(0);
    tick(1);
    tick(2);
    tick(3);
    tick(0);
    req = '0;
    tick(-1);
    tick(-1);
    tick(-1);

    // Single requester held for six edges: served every other cycle
    set_pos(3, 640, 470);
    req = 4'b1000;
    tick(3);
    tick(-1);
    tick(3);
    tick(-1);
    tick(3);
    tick(-1);
    req = '0;
    tick(-1);
    tick(-1);

    // Three of four held: ordering with and without requester-0 priority
    set_pos(0, 40, 60);
    set_pos(1, 120, 180);
    set_pos(3, 400, 300);
    req = 4'b1011;
`ifdef GRID_ARB_PRIO0_EN
    tick(0);
    tick(1);
    tick(0);
    tick(3);
    tick(0);
    tick(1);
`else
    tick(0);
    tick(1);
    tick(3);
    tick(0);
    tick(1);
    tick(3);
`endif
    req = '0;
    tick(-1);
    tick(-1);
    tick(-1);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
